// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: two-requester round-robin UART transmitter (8N1, STOP_BITS stop bits).
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_scheduler #(
  parameter int TICKS_PER_BIT = 16,
  parameter int STOP_BITS = 1
) (
  input  logic       clk50MHz,
  input  logic       rst,
  input  logic       baudTick,
  input  logic       reqA,
  input  logic [7:0] dataA,
  output logic       ackA,
  input  logic       reqB,
  input  logic [7:0] dataB,
  output logic       ackB,
  output logic       txd,
  output logic       busy,
  output logic       grantId
);
  localparam int CW = TICKS_PER_BIT > 1 ? $clog2(TICKS_PER_BIT) : 1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] data, data_n;
  logic txd_n, gid_n, grant_a, grant_b, bit_done;
  // grantId doubles as last-served: B wins a tie only if A was served last
  assign grant_b = state == IDLE && reqB && (!reqA || !grantId);
  assign grant_a = state == IDLE && reqA && !grant_b;
  assign bit_done = baudTick && cnt == CW'(TICKS_PER_BIT - 1);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    data_n = data;
    txd_n = txd;
    gid_n = grantId;
    ackA = grant_a && !rst;
    ackB = grant_b && !rst;
    if (state != IDLE && baudTick) cnt_n = bit_done ? '0 : cnt + 1'b1;
    case (state)
      IDLE: if (grant_a || grant_b) begin
        state_n = START;
        txd_n = 1'b0;
        data_n = grant_b ? dataB : dataA;
        gid_n = grant_b;
        idx_n = '0;
        cnt_n = '0;
      end
      START: if (bit_done) begin
        state_n = DATA;
        txd_n = data[0];
      end
      DATA: if (bit_done) begin
        if (idx == 3'd7) begin
          idx_n = '0;
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
          txd_n = ^data;
`else
          state_n = STOP;
          txd_n = 1'b1;
`endif
        end else begin
          idx_n = idx + 3'd1;
          txd_n = data[idx + 3'd1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) begin
        state_n = STOP;
        txd_n = 1'b1;
      end
`endif
      STOP: if (bit_done) begin
        state_n = idx == 3'(STOP_BITS - 1) ? IDLE : STOP;
        idx_n = idx == 3'(STOP_BITS - 1) ? 3'd0 : idx + 3'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      txd <= 1'b1;
      grantId <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      data <= data_n;
      txd <= txd_n;
      grantId <= gid_n;
    end
  end
endmodule
